regfile_wb_arbiter: RTL and testbench

- Shares the register bank's single write port between two write-back requesters: the ALU result path and the load/memory path.
- Uses valid/ready handshakes with round-robin arbitration.
- Drives registered write-enable, write-address and write-data into the register bank.
- Optionally keeps a per-register busy scoreboard so decode can stall on RAW/WAW hazards against in-flight writes.

---
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the ALU and load write-back paths onto the
// single register-bank write port using round-robin valid/ready handshakes.
// Optional busy scoreboard for decode hazard stalls: define RF_SCOREBOARD_EN.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data   ALU write-back request;  alu_ready accept (comb)
//   mem_valid/mem_rd/mem_data   load write-back request; mem_ready accept (comb)
//   issue_valid/issue_rd/rs1/rs2  instruction being issued by decode
//   stall                       decode must hold (comb; 0 without scoreboard)
//   rf_we/rf_waddr/rf_wdata     registered register-bank write port
//   contention_cnt              saturating count of cycles with both valid
module regfile_wb_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG   = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  contention_cnt
);

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_e;

  grant_e            last_grant;
  logic              grant;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;
  logic              contend;

  // Round-robin grant: on contention the side not granted last wins.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    contend   = alu_valid && mem_valid;
    if (rst_n) begin
      if (contend) begin
        if (last_grant == GRANT_MEM) alu_ready = 1'b1;
        else                         mem_ready = 1'b1;
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
    grant    = alu_ready || mem_ready;
    win_rd   = mem_ready ? mem_rd   : alu_rd;
    win_data = mem_ready ? mem_data : alu_data;
  end

  // Write port register; writes to x0 are accepted but never reach the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      last_grant <= GRANT_ALU;
    end else begin
      rf_we <= grant && (win_rd != '0);
      if (grant && (win_rd != '0)) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
      if (alu_ready)      last_grant <= GRANT_ALU;
      else if (mem_ready) last_grant <= GRANT_MEM;
    end
  end

  // Saturating contention counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention_cnt <= '0;
    end else if (contend && (contention_cnt != {CNT_W{1'b1}})) begin
      contention_cnt <= contention_cnt + CNT_W'(1);
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // x0 is never set, so it never reads as busy.
  always_comb begin
    stall    = issue_valid && (busy[rs1] || busy[rs2] || busy[issue_rd]);
    busy_nxt = busy;
    if (rf_we) busy_nxt[rf_waddr] = 1'b0;
    // Set after clear so a simultaneous set of the same index wins.
    if (issue_valid && !stall && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_rd, rs1, rs2};
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of regfile_wb_arbiter
// against a behavioural model (turn flag, expected write, count, busy set).
// Scoreboard checks are compiled in when RF_SCOREBOARD_EN is defined.
module tb_regfile_wb_arbiter;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREG   = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              alu_valid, mem_valid, issue_valid;
  logic [ADDR_W-1:0] alu_rd, mem_rd, issue_rd, rs1, rs2;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_ready, mem_ready, stall, rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  contention_cnt;

  regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2), .stall(stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .contention_cnt(contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  bit                m_mem_turn;   // mem wins the next contention
  bit                m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  int                m_cnt;
  bit                m_busy [NREG];

  // Results of the last cycle, used by stimulus and directed checks
  bit alu_acc, mem_acc, s_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mem_turn = 1'b1;
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_cnt = 0;
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
  endtask

  // Called just after a falling edge with inputs driven; returns at next falling edge.
  task automatic run_cycle();
    bit g_alu, g_mem, e_stall;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] d;
    #1;
    g_alu = 1'b0;
    g_mem = 1'b0;
    if (alu_valid && mem_valid) begin
      if (m_mem_turn) g_mem = 1'b1;
      else            g_alu = 1'b1;
    end else begin
      g_alu = alu_valid;
      g_mem = mem_valid;
    end
`ifdef RF_SCOREBOARD_EN
    e_stall = issue_valid && (m_busy[rs1] || m_busy[rs2] || m_busy[issue_rd]);
`else
    e_stall = 1'b0;
`endif
    chk("alu_ready", 64'(alu_ready), 64'(g_alu));
    chk("mem_ready", 64'(mem_ready), 64'(g_mem));
    chk("stall", 64'(stall), 64'(e_stall));
    s_stall = stall;
    @(posedge clk);
    if (m_we) m_busy[m_waddr] = 1'b0;
    if (issue_valid && !e_stall && issue_rd != '0) m_busy[issue_rd] = 1'b1;
    if (g_alu || g_mem) begin
      rd = g_mem ? mem_rd : alu_rd;
      d  = g_mem ? mem_data : alu_data;
      m_we = (rd != '0);
      if (rd != '0) begin
        m_waddr = rd;
        m_wdata = d;
      end
      if (alu_valid && mem_valid) m_mem_turn = g_alu;
      else                        m_mem_turn = g_alu;
    end else begin
      m_we = 1'b0;
    end
    if (alu_valid && mem_valid && m_cnt < CNT_MAX) m_cnt++;
    alu_acc = g_alu;
    mem_acc = g_mem;
    #1;
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    chk("contention_cnt", 64'(contention_cnt), 64'(m_cnt));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    alu_rd = '0; mem_rd = '0; issue_rd = '0; rs1 = '0; rs2 = '0;
    alu_data = '0; mem_data = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h1111;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h2222;
    repeat (3) @(negedge clk);
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_cnt", 64'(contention_cnt), 64'd0);
    rst_n = 1'b1;

    // Four contended cycles: mem, alu, mem, alu
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      chk("contend_mem_grant", 64'(mem_acc), 64'((i % 2) == 0));
      chk("contend_we", 64'(rf_we), 64'd1);
      if (alu_acc) begin alu_rd = 5'(3 + i); alu_data = 64'(16'hA000 + i); end
      if (mem_acc) begin mem_rd = 5'(10 + i); mem_data = 64'(16'hB000 + i); end
    end
    chk("contend_cnt4", 64'(contention_cnt), 64'd4);
    idle_inputs();
    run_cycle();

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD;
    run_cycle();
    chk("alu_single_ready", 64'(alu_ready || alu_acc), 64'd1);
    chk("alu_single_waddr", 64'(rf_waddr), 64'd5);
    chk("alu_single_wdata", 64'(rf_wdata), 64'hDEAD);
    idle_inputs();
    run_cycle();
    chk("alu_single_we_off", 64'(rf_we), 64'd0);

    // Write to x0: accepted, no write, port holds
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hBEEF;
    run_cycle();
    chk("x0_accept", 64'(alu_acc), 64'd1);
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_waddr_hold", 64'(rf_waddr), 64'd5);
    chk("x0_wdata_hold", 64'(rf_wdata), 64'hDEAD);
    idle_inputs();
    run_cycle();

`ifdef RF_SCOREBOARD_EN
    issue_valid = 1'b1; issue_rd = 5'd7;
    run_cycle();
    issue_rd = 5'd8; rs1 = 5'd7;
    run_cycle();
    chk("sb_raw_stall", 64'(s_stall), 64'd1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
    run_cycle();
    chk("sb_stall_grant_cycle", 64'(s_stall), 64'd1);
    chk("sb_commit_we", 64'(rf_we), 64'd1);
    alu_valid = 1'b0;
    issue_rd = 5'd7; rs1 = 5'd0;
    run_cycle();
    chk("sb_stall_commit_cycle", 64'(s_stall), 64'd1);
    run_cycle();
    chk("sb_stall_released", 64'(s_stall), 64'd0);
    issue_rd = 5'd9; rs1 = 5'd7;
    run_cycle();
    chk("sb_rd7_busy_again", 64'(s_stall), 64'd1);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h78;
    run_cycle();
    idle_inputs();
    run_cycle();
`endif

    // Randomized traffic, holding each request until accepted
    alu_acc = 1'b0; mem_acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst_n = 1'b0;
        #1;
        chk("midrst_we", 64'(rf_we), 64'd0);
        chk("midrst_alu_ready", 64'(alu_ready), 64'd0);
        chk("midrst_cnt", 64'(contention_cnt), 64'd0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle();
        chk("midrst_no_we", 64'(rf_we), 64'd0);
        alu_acc = 1'b0; mem_acc = 1'b0;
      end
      if (!alu_valid || alu_acc) begin
        alu_valid = ($urandom % 4) != 0;
        alu_rd = 5'($urandom_range(0, 7));
        alu_data = {$urandom, $urandom};
      end
      if (!mem_valid || mem_acc) begin
        mem_valid = ($urandom % 3) != 0;
        mem_rd = 5'($urandom_range(0, 7));
        mem_data = {$urandom, $urandom};
      end
      issue_valid = ($urandom % 2) != 0;
      issue_rd = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      run_cycle();
    end

    // Saturation: more than 2**CNT_W contended cycles
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd1; mem_valid = 1'b1; mem_rd = 5'd2;
    repeat ((1 << CNT_W) + 3) @(posedge clk);
    #1;
    chk("cnt_saturated", 64'(contention_cnt), 64'(CNT_MAX));
    @(posedge clk);
    #1;
    chk("cnt_no_wrap", 64'(contention_cnt), 64'(CNT_MAX));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
